// File: rtl/pin_report_tx.sv
// Pin-check reporter: snapshots per-channel pass flags on a start pulse and streams
// "PASS"/"FAIL", an optional per-channel 0/1 map, then CR LF over a UART byte handshake.
module pin_report_tx #(
  parameter int NUM_CH     = 8,
  parameter int DETAIL     = 1,
  parameter int GAP_CYCLES = 600,
  parameter int TO_CYCLES  = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              report_start,
  input  logic [NUM_CH-1:0] pin_ok,
  input  logic              tx_busy,
  input  logic              tx_complete,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              report_busy,
  output logic              report_done,
  output logic              all_pass,
  output logic              tx_timeout
);

  localparam int FRAME_LEN = 4 + ((DETAIL != 0) ? (1 + NUM_CH) : 0) + 2;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TO_W      = (TO_CYCLES > 1) ? $clog2(TO_CYCLES + 1) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] CR_IDX   = IDX_W'(FRAME_LEN - 2);
  localparam logic [IDX_W-1:0] MAP_BASE = IDX_W'(5);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    GAP,
    DONE
  } state_t;

  state_t            state;
  logic [NUM_CH-1:0] snap;
  logic [IDX_W-1:0]  idx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [7:0]        next_byte;
  logic [7:0]        ch_char [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch_char
      assign ch_char[gi] = snap[gi] ? 8'h31 : 8'h30;
    end
  endgenerate

  // Byte for the current index: verdict, optional map, then the CR LF terminator.
  always_comb begin
    next_byte = 8'h0A;
    if (idx < IDX_W'(4)) begin
      case (idx[1:0])
        2'd0:    next_byte = all_pass ? 8'h50 : 8'h46;
        2'd1:    next_byte = 8'h41;
        2'd2:    next_byte = all_pass ? 8'h53 : 8'h49;
        default: next_byte = all_pass ? 8'h53 : 8'h4C;
      endcase
    end else if (idx == CR_IDX) begin
      next_byte = 8'h0D;
    end else if (idx == LAST_IDX) begin
      next_byte = 8'h0A;
    end else if (DETAIL != 0) begin
      next_byte = 8'h20;
      for (int i = 0; i < NUM_CH; i++) begin
        if (idx == MAP_BASE + IDX_W'(i)) begin
          next_byte = ch_char[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      snap        <= '0;
      idx         <= '0;
      gap_cnt     <= '0;
      to_cnt      <= '0;
      tx_start    <= 1'b0;
      tx_data     <= 8'h00;
      report_busy <= 1'b0;
      report_done <= 1'b0;
      all_pass    <= 1'b0;
      tx_timeout  <= 1'b0;
    end else begin
      tx_start    <= 1'b0;
      report_done <= 1'b0;
      case (state)
        IDLE: begin
          report_busy <= report_start;
          if (report_start) begin
            snap       <= pin_ok;
            all_pass   <= &pin_ok;
            tx_timeout <= 1'b0;
            idx        <= '0;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          if (!tx_busy) begin
            tx_data  <= next_byte;
            tx_start <= 1'b1;
            to_cnt   <= TO_W'(TO_CYCLES);
            state    <= WAIT;
          end
        end
        WAIT: begin
          // Completion is checked before expiry so a same-cycle completion wins.
          if (tx_complete) begin
            if (idx == LAST_IDX) begin
              state <= DONE;
            end else begin
              idx     <= idx + 1'b1;
              gap_cnt <= GAP_W'(GAP_CYCLES);
              state   <= GAP;
            end
          end else if (to_cnt == '0) begin
            tx_timeout  <= 1'b1;
            report_busy <= 1'b0;
            state       <= IDLE;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt <= GAP_W'(1)) begin
            state <= LAUNCH;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        DONE: begin
          report_done <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pin_report_tx.md
# pin_report_tx

Parametrised pin-check result reporter. It snapshots a vector of per-channel pin-check flags on a start pulse and emits an ASCII report frame through the UART transmitter's byte handshake: `PASS` or `FAIL`, optionally followed by a per-channel `0`/`1` map, then CR LF. It sits between the pin-capture logic and the UART TX block. It enforces a programmable idle gap between bytes and a per-byte completion timeout.

## Interface
- `NUM_CH`, 8: number of pin channels checked (1..32).
- `DETAIL`, 1: 1 = append a space plus a per-channel map after the verdict; 0 = verdict and CR LF only.
- `GAP_CYCLES`, 600: minimum idle clk cycles between a byte's `tx_complete` and the next `tx_start` (>=1).
- `TO_CYCLES`, 65535: max clk cycles to wait for `tx_complete` after `tx_start` before abort.
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: synchronous, active-low reset.
- `report_start` in 1: one-cycle request to send a report; ignored while busy.
- `pin_ok` in NUM_CH: per-channel result, 1 = pass; sampled only on an accepted `report_start`.
- `tx_busy` in 1: UART TX is transmitting; `tx_start` is never asserted while high.
- `tx_complete` in 1: one-cycle pulse from the UART at the end of a byte.
- `tx_start` out 1: one-cycle active-high byte launch strobe.
- `tx_data` out 8: byte to send; stable from `tx_start` until `tx_complete`.
- `report_busy` out 1: high from accepted start until return to IDLE.
- `report_done` out 1: one-cycle pulse when the frame completes normally.
- `all_pass` out 1: verdict of the last snapshot (AND of `pin_ok`); holds until the next accepted start.
- `tx_timeout` out 1: sticky error flag; cleared by the next accepted start or by reset.

## Operation
- Frame length L = 4 + (DETAIL ? 1+NUM_CH : 0) + 2 bytes. The byte index counter is wide enough for L-1.
- Frame bytes:
  - Verdict: `50 41 53 53` ("PASS") if all channels pass, otherwise `46 41 49 4C` ("FAIL").
  - If DETAIL: `20`, then one byte per channel, ch0 first: `31` if pass, `30` if fail.
  - Terminator: `0D 0A`.
- The byte is selected combinationally from the index and the snapshot, and is registered into `tx_data` on launch.
- FSM states:
  - IDLE: wait for `report_start`. On start: latch `pin_ok` into the snapshot, update `all_pass`, clear `tx_timeout`, index=0, go to LAUNCH.
  - LAUNCH: wait for `tx_busy`=0. When low, register the byte into `tx_data`, pulse `tx_start`, load the timeout counter, go to WAIT.
  - WAIT: on `tx_complete`:
    - If index=L-1, go to DONE.
    - Otherwise index+1, load the gap counter, go to GAP.
    - If the timeout counter expires first, set `tx_timeout`, go to IDLE with no `report_done`.
  - GAP: count GAP_CYCLES cycles, then go to LAUNCH.
  - DONE: pulse `report_done`, go to IDLE.
- `tx_complete` outside WAIT is ignored. `report_start` outside IDLE is ignored, and `pin_ok` changes after the snapshot have no effect.
- Counters saturate/reload only as stated; there is no wrap-around of the index past L-1.

## Timing
- Reset values, applied synchronously at the clk edge with `rst_n`=0 and regardless of state:
  - state=IDLE.
  - `tx_start`=0, `tx_data`=8'h00.
  - `report_busy`=0, `report_done`=0, `all_pass`=0, `tx_timeout`=0.
  - Snapshot, index and counters = 0.
- Reset mid-frame aborts immediately; no further `tx_start` is issued.
- Start latency: `report_start` sampled high at edge T gives `report_busy`=1 after T. The first `tx_start` is after T+1 if `tx_busy`=0.
- `tx_start` is high for exactly one cycle. `tx_data` is valid in the same cycle and held until the next launch.
- Gap: `tx_complete` sampled at edge D gives the next `tx_start` after edge D+GAP_CYCLES+1, delayed further while `tx_busy`=1.
- End of frame: the last `tx_complete` at edge D gives `report_done` after D+1 and `report_busy`=0 after D+2.
- Timeout: with no `tx_complete` by TO_CYCLES cycles after `tx_start`, `tx_timeout`=1 and `report_busy`=0 on the following edge.
- Simultaneous `tx_complete` and timeout expiry: completion wins.

## Test plan
- NUM_CH=8, DETAIL=1, `pin_ok`=8'hFF, start -> bytes 50 41 53 53 20 31 31 31 31 31 31 31 31 0D 0A; `all_pass`=1; one `report_done`.
- `pin_ok`=8'hF7 (ch3 fail) -> 46 41 49 4C 20 31 31 31 30 31 31 31 31 0D 0A; `all_pass`=0. With DETAIL=0 -> 46 41 49 4C 0D 0A.
- GAP_CYCLES=600, UART model returns `tx_complete` 10 cycles after launch -> every tx_complete-to-next-tx_start spacing is exactly 601 cycles. Holding `tx_busy`=1 for 50 extra cycles delays that launch by 50 cycles.
- Second `report_start` and toggling `pin_ok` mid-frame -> ignored; the frame content matches the first snapshot and exactly 15 bytes are sent.
- TO_CYCLES=100 with `tx_complete` withheld on byte 2 -> `tx_timeout`=1 at cycle 101 after that launch, no `report_done`, and the next start clears the flag.
- Assert `rst_n`=0 for one cycle after byte 5 -> all outputs at reset values on the next edge and no further `tx_start`. A new start sends a full frame from byte 0.
